// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: sequences idle/gap/up/hit/over phases,
// picks a pseudo-random hole per round and keeps score and miss counts.
module mole_round_ctrl #(
  parameter int          N_HOLES    = 4,
  parameter int          GAP_CYCLES = 25000000,
  parameter int          UP_CYCLES  = 50000000,
  parameter int          HIT_CYCLES = 12500000,
  parameter int          MAX_MISSES = 3,
  parameter int          SCORE_W    = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_HOLES-1:0] btn,
  output logic [N_HOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               busy,
  output logic               game_over
);

  localparam int PW     = $clog2(N_HOLES);
  localparam int MAXC_A = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
  localparam int MAXC   = (MAXC_A > HIT_CYCLES) ? MAXC_A : HIT_CYCLES;
  localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] UP_LAST  = CNT_W'(UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_CYCLES - 1);
  localparam logic [N_HOLES-1:0] ONE    = N_HOLES'(1);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_UP, S_HIT, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] btn_prev_q, btn_prev_d;
  logic [PW-1:0]      prev_pos_q, prev_pos_d;
  logic [N_HOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         misses_q, misses_d;
  logic               hit_q, hit_d, miss_q, miss_d;
  logic               busy_q, busy_d, over_q, over_d;

  logic [N_HOLES-1:0] press;
  logic [PW-1:0]      pos_raw, pos_sel;
  logic [3:0]         misses_inc;
  logic               do_miss;

  assign press      = btn & ~btn_prev_q;
  assign pos_raw    = lfsr_q[PW-1:0];
  // Never light the same hole twice in a row; PW-bit add wraps mod N_HOLES.
  assign pos_sel    = (pos_raw == prev_pos_q) ? pos_raw + 1'b1 : pos_raw;
  assign misses_inc = misses_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    btn_prev_d = btn;
    prev_pos_d = prev_pos_q;
    mole_d     = mole_q;
    score_d    = score_q;
    misses_d   = misses_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    do_miss    = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_GAP;
          cnt_d    = '0;
          score_d  = '0;
          misses_d = '0;
        end
      end
      S_GAP: begin
        mole_d = '0;
        if (cnt_q == GAP_LAST) begin
          state_d    = S_UP;
          cnt_d      = '0;
          mole_d     = ONE << pos_sel;
          prev_pos_d = pos_sel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UP: begin
        // A wrong press outranks a correct one; any press outranks timeout.
        if (|(press & ~mole_q)) begin
          do_miss = 1'b1;
        end else if (|press) begin
          hit_d   = 1'b1;
          score_d = (&score_q) ? score_q : score_q + 1'b1;
          mole_d  = '0;
          cnt_d   = '0;
          state_d = S_HIT;
        end else if (cnt_q == UP_LAST) begin
          do_miss = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (do_miss) begin
          miss_d   = 1'b1;
          misses_d = misses_inc;
          mole_d   = '0;
          cnt_d    = '0;
          state_d  = (misses_inc == 4'(MAX_MISSES)) ? S_OVER : S_GAP;
        end
      end
      S_HIT: begin
        if (cnt_q == HIT_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_GAP) || (state_d == S_UP) || (state_d == S_HIT);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      btn_prev_q <= '1;
      prev_pos_q <= '0;
      mole_q     <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      btn_prev_q <= btn_prev_d;
      prev_pos_q <= prev_pos_d;
      mole_q     <= mole_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      busy_q     <= busy_d;
      over_q     <= over_d;
    end
  end

  assign mole       = mole_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign busy       = busy_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: directed scenarios plus random play, every cycle
// compared against a phase/countdown model of the game rules.
module tb_mole_round_ctrl;
  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int UP  = 8;
  localparam int HIT = 2;
  localparam int MAXM = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] mole;
  logic [7:0]   score;
  logic [3:0]   misses;
  logic         hit_pulse, miss_pulse, busy, game_over;

  mole_round_ctrl #(
    .N_HOLES(N), .GAP_CYCLES(GAP), .UP_CYCLES(UP), .HIT_CYCLES(HIT),
    .MAX_MISSES(MAXM), .SCORE_W(8), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .mole(mole),
    .score(score), .misses(misses), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: phase 0 idle, 1 gap, 2 up, 3 hit, 4 over; m_left counts down.
  int       m_phase, m_left, m_pos, m_prev_pos, m_score, m_misses;
  bit       m_hit, m_miss;
  bit [7:0] m_lfsr;
  bit [N-1:0] m_prev_btn;

  function automatic logic [N-1:0] m_mole();
    return (m_phase == 2) ? (N'(1) << m_pos) : '0;
  endfunction

  task automatic model_update();
    bit [N-1:0] pr, lit;
    bit [7:0] lold;
    if (!reset) begin
      m_phase = 0; m_left = 0; m_pos = 0; m_prev_pos = 0;
      m_score = 0; m_misses = 0; m_hit = 0; m_miss = 0;
      m_lfsr = 8'hA5; m_prev_btn = '1;
      return;
    end
    pr = btn & ~m_prev_btn;
    m_prev_btn = btn;
    lold = m_lfsr;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_hit = 0; m_miss = 0;
    case (m_phase)
      0, 4: if (start) begin m_phase = 1; m_left = GAP; m_score = 0; m_misses = 0; end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_pos = lold % N;
          if (m_pos == m_prev_pos) m_pos = (m_pos + 1) % N;
          m_prev_pos = m_pos;
          m_phase = 2; m_left = UP;
        end
      end
      2: begin
        lit = N'(1) << m_pos;
        m_left--;
        if ((pr & ~lit) != 0 || (pr == 0 && m_left == 0)) begin
          m_misses++; m_miss = 1;
          m_phase = (m_misses == MAXM) ? 4 : 1; m_left = GAP;
        end else if (pr != 0) begin
          m_score = (m_score == 255) ? 255 : m_score + 1; m_hit = 1;
          m_phase = 3; m_left = HIT;
        end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin m_phase = 1; m_left = GAP; end
      end
      default: ;
    endcase
  endtask

  task automatic check();
    logic [19:0] got, exp;
    got = {mole, score, misses, hit_pulse, miss_pulse, busy, game_over};
    exp = {m_mole(), 8'(m_score), 4'(m_misses), m_hit, m_miss,
           (m_phase >= 1 && m_phase <= 3), (m_phase == 4)};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cycle %0d outputs {mole,score,misses,hit,miss,busy,over}: got %h expected %h",
               cyc, got, exp);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1 check();
  endtask

  task automatic wait_mole();
    int k;
    k = 0;
    while (mole == '0 && k < 50) begin step(); k++; end
    if (mole == '0) chk("wait_mole_timeout", 0, 1);
  endtask

  initial begin
    logic [N-1:0] old_mole;
    int npulse, k;

    // Reset with buttons held, then release both.
    reset = 1'b0; btn = '1;
    step(); step();
    reset = 1'b1;
    repeat (3) step();
    btn = '0;
    repeat (3) step();
    chk("idle_busy", busy, 0);
    chk("idle_mole", mole, 0);
    chk("idle_score", score, 0);
    chk("idle_no_pulse", hit_pulse | miss_pulse, 0);

    // Start with no presses: three timeouts end the game.
    start = 1'b1; step(); start = 1'b0;
    chk("start_busy", busy, 1);
    repeat (3) step();
    chk("gap_mole_low", mole, 0);
    step();
    chk("mole_up_after_gap", (mole != 0), 1);
    npulse = 0; k = 0;
    while (!game_over && k < 200) begin step(); npulse += miss_pulse; k++; end
    chk("timeout_over", game_over, 1);
    chk("timeout_misses", misses, 3);
    chk("timeout_pulses", npulse, 3);
    chk("timeout_busy", busy, 0);

    // Restart from OVER, hit the lit hole three cycles into UP.
    start = 1'b1; step(); start = 1'b0;
    chk("restart_clears", misses, 0);
    wait_mole();
    old_mole = mole;
    step(); step();
    btn = mole; step();
    chk("hit_pulse", hit_pulse, 1);
    chk("hit_score", score, 1);
    chk("hit_mole_low", mole, 0);
    btn = '0; step();
    chk("hit_pulse_once", hit_pulse, 0);
    wait_mole();
    chk("next_mole_differs", (mole != old_mole), 1);
    chk("next_mole_onehot", $onehot(mole), 1);

    // Lit and unlit pressed together counts as a miss.
    btn = mole | {mole[N-2:0], mole[N-1]}; step();
    chk("mixed_miss_pulse", miss_pulse, 1);
    chk("mixed_misses", misses, 1);
    chk("mixed_score", score, 1);
    btn = '0;

    // Drive score to saturation.
    for (int i = 0; i < 256; i++) begin
      wait_mole();
      btn = mole; step();
      if (i == 255) begin
        chk("sat_hit_pulse", hit_pulse, 1);
        chk("sat_score", score, 255);
      end
      btn = '0; step();
    end

    // start ignored in UP, then reset mid-round.
    wait_mole();
    start = 1'b1; step(); start = 1'b0;
    chk("start_ignored_busy", busy, 1);
    chk("start_ignored_score", score, 255);
    reset = 1'b0; step(); reset = 1'b1;
    chk("rst_mole", mole, 0);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", hit_pulse | miss_pulse, 0);

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0: btn = N'($urandom);
        1, 2: btn = m_mole();
        3: btn = '0;
        default: ;
      endcase
      step();
    end
    reset = 1'b1; start = 1'b0; btn = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
